dram_ctrl_ru6: RTL
==================

Name: dram_ctrl_ru6

Overview:
- Memory controller stage directly upstream of the two byte-lane 16K×8 RU6 DRAM models (low/high byte), which share RAS/WE/MA and have separate CAS.
- Accepts 16-bit word requests from the CPU/bus side over a valid/ready handshake.
- Multiplexes the 14-bit word address into row/column phases on the 7-bit MA bus and sequences RAS/CAS/WE.
- Captures read data and inserts RAS-only refresh cycles.

Parameters:
- RCD, 1, clocks RAS held low with row address before column setup (≥1).
- CAS_W, 2, clocks CAS held low (≥1).
- PRE, 2, precharge clocks with all strobes high before next cycle (≥1).
- REF_PERIOD, 64, clocks between refresh requests (≥8).

Ports:
- pin_clk  in  1  system clock; all state on rising edge.
- pin_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  14  word address; row = [6:0], col = [13:7].
- req_be  in  2  byte enables for writes ([0] low lane, [1] high lane); ignored on reads.
- req_wdata  in  16  write data.
- rsp_ack  out  1  one-clock completion pulse, reads and writes.
- rsp_rdata  out  16  read data, valid while rsp_ack = 1 for a read, held until next read.
- ram_ma  out  7  multiplexed address.
- ram_di  out  16  data to RAM lanes ([7:0] low, [15:8] high).
- ram_do  in  16  data from RAM; Z outside read CAS.
- ram_ras_n  out  1  row strobe.
- ram_cas_n  out  2  per-lane column strobes.
- ram_we_n  out  1  write enable.

Behaviour:
- Reset (async, immediate):
  - Strobes high: ras_n = 1, cas_n = 2'b11, we_n = 1.
  - ram_ma = 0, ram_di = 0, rsp_ack = 0, rsp_rdata = 0.
  - State IDLE; refresh row and refresh timer cleared; ref_pend = 0.
  - Reset mid-cycle aborts the access with no ack.
- Handshake:
  - req_ready = (state == IDLE) & ~ref_pend; combinational.
  - Transfer occurs when req_valid & req_ready at a clock edge.
  - we, addr, be and wdata are registered at transfer; inputs are don't-care afterwards.
- States and durations:
  - IDLE
  - ROW_SET (1): ma = row, ras_n = 1.
  - RAS (RCD): ras_n = 0, ma = row.
  - COL_SET (1): ras_n = 0, ma = col; we_n = ~we; ram_di = wdata.
  - CAS (CAS_W): cas_n lanes low, ma/we_n/di held.
  - PRE (PRE): all strobes high, ma holds last value.
  - REF_SET (1): ma = refresh row, strobes high.
  - REF_RAS (RCD + CAS_W): ras_n = 0, cas_n = 11.
- Strobe ordering:
  - MA changes only while the strobe that latches it is high.
  - we_n settles one clock before any CAS falls.
  - we_n returns high in PRE, never before CAS rises.
- CAS lanes:
  - Read: both lanes low.
  - Write: lane i low only if be[i].
  - Write with be = 00: RAS-only cycle, still acked.
- Read capture: rsp_rdata <= ram_do on the edge ending the last CAS clock.
- Ack timing:
  - rsp_ack = 1 in the first PRE clock.
  - Latency from transfer edge to ack: 2 + RCD + CAS_W clocks (defaults: 5).
  - Back-to-back cycle time, transfer to next transfer: 2 + RCD + CAS_W + PRE + 1 clocks (defaults: 8).
- Refresh:
  - Timer counts 0..REF_PERIOD-1; at wrap it sets ref_pend. A further wrap while pending does not accumulate.
  - In IDLE, ref_pend wins over req_valid.
  - Refresh path: REF_SET → REF_RAS → PRE; no ack.
  - On leaving REF_RAS: ref_pend clears and the refresh row increments mod 128 (127 → 0).
  - Refresh never preempts an access in progress.

Optional Feature:
- DRAM_REFRESH_EN.
- Defined: timer, refresh row counter and REF_* states present as above.
- Undefined: no refresh logic; ref_pend is constant 0; req_ready = (state == IDLE); REF_* states absent.

Decomposition:
- Package dram_ru6_pkg holds:
  - State enum.
  - Width constants: MA_W = 7, ADDR_W = 14, DATA_W = 16, LANES = 2.
  - Row/col slice helpers.
- One sub-module: dram_refresh_timer (REF_PERIOD counter, ref_pend, 7-bit row counter, advance input), instantiated only under DRAM_REFRESH_EN.

Test Plan:
1. Write addr 14'h1F85, data 16'hA55A, be 11, then read it back.
   - MA shows 7'h05 then 7'h3F.
   - rsp_rdata = 16'hA55A with ack 5 clocks after transfer.
2. Write 16'hFFFF to 14'h0100, then write 16'h1234 be = 01, then read.
   - Result 16'hFF34.
   - Only ram_cas_n[0] falls on the second write.
3. Hold req_valid continuously with defaults.
   - Transfers every 8 clocks.
   - we_n never low while ras_n high.
   - No CAS fall in the same clock as an MA change.
4. DRAM_REFRESH_EN, REF_PERIOD = 16, idle 2100 clocks.
   - 131 RAS-only cycles.
   - ma sequence 0..127, 0, 1, 2 (row wraps).
   - cas_n stays 11.
5. Request valid in the same clock ref_pend rises.
   - Refresh cycle first, then access.
   - Access acked; data intact.
6. Assert pin_rst_n low during CAS of a write.
   - Strobes high immediately, no ack.
   - After release, req_ready = 1 at first clock.
   - Refresh row = 0.

Source files
------------

// File: rtl/dram_ru6_pkg.sv
// dram_ru6_pkg: shared states, widths and address slice helpers; REF_* states exist only with DRAM_REFRESH_EN
package dram_ru6_pkg;
   localparam int MA_W   = 7;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 16;
   localparam int LANES  = 2;
   typedef enum logic [2:0] {
      S_IDLE, S_ROW_SET, S_RAS, S_COL_SET, S_CAS, S_PRE
`ifdef DRAM_REFRESH_EN
      , S_REF_SET, S_REF_RAS
`endif
   } state_t;
   function automatic logic [MA_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      return a[MA_W-1:0];
   endfunction
   function automatic logic [MA_W-1:0] col_of(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:MA_W];
   endfunction
endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: refresh interval counter, pending flag and RAS-only row counter (used with DRAM_REFRESH_EN)
module dram_refresh_timer
   import dram_ru6_pkg::*;
#(
   parameter int REF_PERIOD = 64
) (
   input  logic            pin_clk,
   input  logic            pin_rst_n,
   input  logic            i_advance,
   output logic            o_ref_pend,
   output logic [MA_W-1:0] o_row
);
   logic [15:0]     r_cnt;
   logic            r_pend;
   logic [MA_W-1:0] r_row;
   logic            w_wrap;
   assign w_wrap     = r_cnt == 16'(REF_PERIOD - 1);
   assign o_ref_pend = r_pend;
   assign o_row      = r_row;
   // count the interval, raise pending at each wrap and retire it when a refresh completes
   always_ff @(posedge pin_clk or negedge pin_rst_n) begin
      if (!pin_rst_n) begin
         r_cnt  <= '0;
         r_pend <= 1'b0;
         r_row  <= '0;
      end else begin
         r_cnt  <= w_wrap ? '0 : r_cnt + 16'd1;
         r_pend <= w_wrap | (r_pend & ~i_advance);
         r_row  <= i_advance ? r_row + 7'd1 : r_row;
      end
   end
endmodule

// File: rtl/dram_ctrl_ru6.sv
// dram_ctrl_ru6: RU6 DRAM sequencer (row/col mux, RAS/CAS/WE timing, read capture); refresh via DRAM_REFRESH_EN
module dram_ctrl_ru6
   import dram_ru6_pkg::*;
#(
   parameter int RCD        = 1,
   parameter int CAS_W      = 2,
   parameter int PRE        = 2,
   parameter int REF_PERIOD = 64
) (
   input  logic              pin_clk,
   input  logic              pin_rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LANES-1:0]  req_be,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_ack,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [MA_W-1:0]   ram_ma,
   output logic [DATA_W-1:0] ram_di,
   input  logic [DATA_W-1:0] ram_do,
   output logic              ram_ras_n,
   output logic [LANES-1:0]  ram_cas_n,
   output logic              ram_we_n
);
   state_t            r_state, w_nxt;
   logic [7:0]        r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [LANES-1:0]  r_be;
   logic [DATA_W-1:0] r_wdata;
   logic [MA_W-1:0]   r_ma, w_ma;
   logic              r_ras_n, w_ras_n;
   logic [LANES-1:0]  r_cas_n, w_cas_n;
   logic              r_we_n, w_we_n;
   logic [DATA_W-1:0] r_di, w_di;
   logic              r_ack;
   logic [DATA_W-1:0] r_rdata;
   logic              w_ref_pend;
   logic              w_xfer;
   logic              w_cas_end;
`ifdef DRAM_REFRESH_EN
   logic              w_advance;
   logic [MA_W-1:0]   w_ref_row;
   assign w_advance = (r_state == S_REF_RAS) && (w_nxt != S_REF_RAS);
   dram_refresh_timer #(.REF_PERIOD(REF_PERIOD)) u_refresh (
      .pin_clk    (pin_clk),
      .pin_rst_n  (pin_rst_n),
      .i_advance  (w_advance),
      .o_ref_pend (w_ref_pend),
      .o_row      (w_ref_row)
   );
`else
   logic              w_unused_ref;
   assign w_ref_pend   = 1'b0;
   assign w_unused_ref = REF_PERIOD != 0;
`endif
   assign req_ready = (r_state == S_IDLE) & ~w_ref_pend;
   assign w_xfer    = req_valid & req_ready;
   assign w_cas_end = (r_state == S_CAS) && (w_nxt == S_PRE);
   assign ram_ma    = r_ma;
   assign ram_di    = r_di;
   assign ram_ras_n = r_ras_n;
   assign ram_cas_n = r_cas_n;
   assign ram_we_n  = r_we_n;
   assign rsp_ack   = r_ack;
   assign rsp_rdata = r_rdata;
   // next state: pending refresh beats a new request in IDLE; timed states leave on their last clock
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: begin
`ifdef DRAM_REFRESH_EN
            if (w_ref_pend) w_nxt = S_REF_SET;
            else
`endif
            if (w_xfer) w_nxt = S_ROW_SET;
         end
         S_ROW_SET: w_nxt = S_RAS;
         S_RAS:     w_nxt = (r_cnt == 8'(RCD - 1)) ? S_COL_SET : S_RAS;
         S_COL_SET: w_nxt = S_CAS;
         S_CAS:     w_nxt = (r_cnt == 8'(CAS_W - 1)) ? S_PRE : S_CAS;
         S_PRE:     w_nxt = (r_cnt == 8'(PRE - 1)) ? S_IDLE : S_PRE;
`ifdef DRAM_REFRESH_EN
         S_REF_SET: w_nxt = S_REF_RAS;
         S_REF_RAS: w_nxt = (r_cnt == 8'(RCD + CAS_W - 1)) ? S_PRE : S_REF_RAS;
`endif
         default:   w_nxt = S_IDLE;
      endcase
   end
   // pin values for the state being entered, so they are registered and glitch-free
   always_comb begin
      w_ma    = r_ma;
      w_ras_n = 1'b1;
      w_cas_n = '1;
      w_we_n  = 1'b1;
      w_di    = r_di;
      case (w_nxt)
         S_ROW_SET: w_ma = row_of(req_addr);
         S_RAS:     w_ras_n = 1'b0;
         S_COL_SET: begin
            w_ras_n = 1'b0;
            w_ma    = col_of(r_addr);
            w_we_n  = ~r_we;
            w_di    = r_wdata;
         end
         S_CAS: begin
            w_ras_n = 1'b0;
            w_we_n  = ~r_we;
            w_cas_n = r_we ? ~r_be : '0;
         end
`ifdef DRAM_REFRESH_EN
         S_REF_SET: w_ma = w_ref_row;
         S_REF_RAS: w_ras_n = 1'b0;
`endif
         default: ;
      endcase
   end
   // state, phase counter, request capture, pins, ack pulse and read capture at the end of CAS
   always_ff @(posedge pin_clk or negedge pin_rst_n) begin
      if (!pin_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_ma    <= '0;
         r_ras_n <= 1'b1;
         r_cas_n <= '1;
         r_we_n  <= 1'b1;
         r_di    <= '0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= (w_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;
         r_we    <= w_xfer ? req_we : r_we;
         r_addr  <= w_xfer ? req_addr : r_addr;
         r_be    <= w_xfer ? req_be : r_be;
         r_wdata <= w_xfer ? req_wdata : r_wdata;
         r_ma    <= w_ma;
         r_ras_n <= w_ras_n;
         r_cas_n <= w_cas_n;
         r_we_n  <= w_we_n;
         r_di    <= w_di;
         r_ack   <= w_cas_end;
         r_rdata <= (w_cas_end && !r_we) ? ram_do : r_rdata;
      end
   end
endmodule
